// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Shared state encoding, parity-mode constants and parameter legality check
// for the parametrised UART receiver.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Wide enough for the largest field: 9 data bits or 2 stop bits.
  localparam int C_BIT_CNT_W = 4;

  function automatic bit cfg_ok(input int width, input int parity,
                                input int stop_bits, input int oversample);
    return (width >= 5) && (width <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (oversample >= 4) && ((oversample % 2) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line plus falling-edge
// detect on the synchronised value. All flops reset to the idle level (1).
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rxs,
  output logic fall
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_d <= 1'b1;
    end else begin
      r_s1   <= rx_in;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign rxs  = r_s2;
  assign fall = r_s2_d & ~r_s2;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_param
// Oversampling UART receive engine with configurable width, parity, stop bits
// and oversampling ratio; false-start rejection and break handling.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             rx_in,
  output logic [WIDTH-1:0] d_out,
  output logic             fifo_we,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  if (!cfg_ok(WIDTH, PARITY, STOP_BITS, OVERSAMPLE)) begin : g_cfg_bad
    $error("uart_rx_param: illegal WIDTH/PARITY/STOP_BITS/OVERSAMPLE");
  end

  localparam int C_TICK_W = $clog2(OVERSAMPLE);

  localparam logic [C_TICK_W-1:0]    C_HALF_LAST = C_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [C_TICK_W-1:0]    C_FULL_LAST = C_TICK_W'(OVERSAMPLE - 1);
  localparam logic [C_BIT_CNT_W-1:0] C_DATA_LAST = C_BIT_CNT_W'(WIDTH - 1);
  localparam logic [C_BIT_CNT_W-1:0] C_STOP_LAST = C_BIT_CNT_W'(STOP_BITS - 1);
  localparam logic                   C_ODD       = (PARITY == PAR_ODD);
  localparam logic                   C_HAS_PAR   = (PARITY != PAR_NONE);

  logic w_rxs;
  logic w_fall;
  logic w_stop_bad;
  logic w_full_tick;

  rx_state_t              r_state;
  logic [C_TICK_W-1:0]    r_tick;
  logic [C_BIT_CNT_W-1:0] r_bit;
  logic [WIDTH-1:0]       r_shift;
  logic                   r_par;
  logic                   r_par_bad;
  logic                   r_frame_bad;
  logic [WIDTH-1:0]       r_d_out;
  logic                   r_we;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_busy;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rxs   (w_rxs),
    .fall  (w_fall)
  );

  // Mid-bit sample strobe for data, parity and stop fields.
  assign w_full_tick = baud_tick && (r_tick == C_FULL_LAST);
  assign w_stop_bad  = r_frame_bad | ~w_rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_par_bad   <= 1'b0;
      r_frame_bad <= 1'b0;
      r_d_out     <= '0;
      r_we        <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state     <= ST_START;
            r_busy      <= 1'b1;
            r_tick      <= '0;
            r_bit       <= '0;
            r_par       <= 1'b0;
            r_par_bad   <= 1'b0;
            r_frame_bad <= 1'b0;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            if (r_tick == C_HALF_LAST) begin
              r_tick <= '0;
              if (w_rxs) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (w_full_tick) begin
            r_tick  <= '0;
            r_shift <= {w_rxs, r_shift[WIDTH-1:1]};
            r_par   <= r_par ^ w_rxs;
            if (r_bit == C_DATA_LAST) begin
              r_bit   <= '0;
              r_state <= C_HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else if (baud_tick) begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_full_tick) begin
            r_tick    <= '0;
            r_par_bad <= ((r_par ^ w_rxs) != C_ODD);
            r_state   <= ST_STOP;
          end else if (baud_tick) begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_full_tick) begin
            r_tick      <= '0;
            r_frame_bad <= w_stop_bad;
            if (r_bit == C_STOP_LAST) begin
              r_bit <= '0;
              if (!(r_par_bad || w_stop_bad)) begin
                r_d_out <= r_shift;
                r_we    <= 1'b1;
              end else begin
                r_perr <= r_par_bad;
                r_ferr <= w_stop_bad;
              end
              // A low final stop sample means break/stuck line: hold off new starts.
              r_state <= w_rxs ? ST_IDLE : ST_WAIT_HIGH;
              r_busy  <= ~w_rxs;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else if (baud_tick) begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          if (w_rxs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign d_out      = r_d_out;
  assign fifo_we    = r_we;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_param
// Self-checking bench: four receiver configurations driven from a frame-level
// line model; outcomes predicted from frame contents and bit timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst;
  logic baud_tick = 1'b0;
  logic div = 1'b0;
  int   tick_count = 0;

  logic rx [4];
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [8:0] dout [4];
  logic we [4], pe [4], fe [4], busy [4];

  // Instance configs: {width, parity, stop bits, oversample}
  int cfg_w  [4] = '{8, 8, 8, 5};
  int cfg_p  [4] = '{1, 2, 0, 1};
  int cfg_s  [4] = '{1, 1, 2, 1};
  int cfg_os [4] = '{16, 16, 16, 8};

  int n_checks = 0;
  int n_errors = 0;

  int n_we [4], n_pe [4], n_fe [4], n_rise [4], n_wide [4];
  int b_we [4], b_pe [4], b_fe [4], b_rise [4];
  int last_word [4], prev_word [4], exp_word [4];
  int rise_t [4], lat [4];
  bit p_we [4], p_pe [4], p_fe [4], p_busy [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div       <= ~div;
    baud_tick <= div;
    if (baud_tick) tick_count <= tick_count + 1;
  end

  uart_rx_param #(.WIDTH(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx[0]), .d_out(d0),
    .fifo_we(we[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(busy[0]));
  uart_rx_param #(.WIDTH(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx[1]), .d_out(d1),
    .fifo_we(we[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(busy[1]));
  uart_rx_param #(.WIDTH(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx[2]), .d_out(d2),
    .fifo_we(we[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(busy[2]));
  uart_rx_param #(.WIDTH(5), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(8)) u3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx[3]), .d_out(d3),
    .fifo_we(we[3]), .parity_err(pe[3]), .frame_err(fe[3]), .busy(busy[3]));

  assign dout[0] = {1'b0, d0};
  assign dout[1] = {1'b0, d1};
  assign dout[2] = {1'b0, d2};
  assign dout[3] = {4'b0, d3};

  // Event monitor: counts strobes, captures words, measures edge-to-result ticks.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k] === 1'b1) begin
        n_we[k]++;
        prev_word[k] = last_word[k];
        last_word[k] = int'(dout[k]);
      end
      if (pe[k] === 1'b1) n_pe[k]++;
      if (fe[k] === 1'b1) n_fe[k]++;
      if (busy[k] === 1'b1 && !p_busy[k]) begin
        n_rise[k]++;
        rise_t[k] = tick_count;
      end
      if (we[k] === 1'b1 || pe[k] === 1'b1 || fe[k] === 1'b1) lat[k] = tick_count - rise_t[k];
      if ((we[k] === 1'b1 && p_we[k]) || (pe[k] === 1'b1 && p_pe[k]) || (fe[k] === 1'b1 && p_fe[k]))
        n_wide[k]++;
      p_we[k]   = (we[k] === 1'b1);
      p_pe[k]   = (pe[k] === 1'b1);
      p_fe[k]   = (fe[k] === 1'b1);
      p_busy[k] = (busy[k] === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick_count;
    while (tick_count - t0 < n) @(negedge clk);
  endtask

  task automatic drive(input int k, input logic v, input int n);
    rx[k] = v;
    wait_ticks(n);
  endtask

  task automatic send(input int k, input int data, input bit flip, input bit bad_stop);
    logic [8:0] d;
    logic       pbit;
    d = 9'(data);
    drive(k, 1'b0, cfg_os[k]);
    for (int i = 0; i < cfg_w[k]; i++) drive(k, d[i], cfg_os[k]);
    if (cfg_p[k] != 0) begin
      pbit = 1'b0;
      for (int i = 0; i < cfg_w[k]; i++) pbit = pbit ^ d[i];
      if (cfg_p[k] == 2) pbit = ~pbit;
      drive(k, pbit ^ flip, cfg_os[k]);
    end
    for (int i = 0; i < cfg_s[k]; i++) drive(k, ~bad_stop, cfg_os[k]);
  endtask

  task automatic mark(input int k);
    b_we[k] = n_we[k];
    b_pe[k] = n_pe[k];
    b_fe[k] = n_fe[k];
    b_rise[k] = n_rise[k];
  endtask

  function automatic int exp_lat(input int k);
    return cfg_os[k] / 2 + cfg_os[k] * (cfg_w[k] + ((cfg_p[k] != 0) ? 1 : 0) + cfg_s[k]);
  endfunction

  task automatic check_frame(input int k, input int e_we, input int e_pe, input int e_fe,
                             input string tag);
    check({tag, " fifo_we count"}, 32'(n_we[k] - b_we[k]), 32'(e_we));
    check({tag, " parity_err count"}, 32'(n_pe[k] - b_pe[k]), 32'(e_pe));
    check({tag, " frame_err count"}, 32'(n_fe[k] - b_fe[k]), 32'(e_fe));
    check({tag, " d_out"}, 32'(dout[k]), 32'(exp_word[k]));
    check({tag, " busy idle"}, 32'(busy[k]), 32'd0);
    if (e_we + e_pe + e_fe > 0) begin
      check({tag, " result ticks"}, 32'(lat[k]), 32'(exp_lat(k)));
      if (e_we > 0) check({tag, " captured word"}, 32'(last_word[k]), 32'(exp_word[k]));
    end
  endtask

  task automatic frame(input int k, input int data, input bit flip, input bit bad_stop,
                       input string tag);
    mark(k);
    send(k, data, flip, bad_stop);
    drive(k, 1'b1, 2 * cfg_os[k]);
    if (!(flip || bad_stop)) exp_word[k] = data & ((1 << cfg_w[k]) - 1);
    check_frame(k, (flip || bad_stop) ? 0 : 1, flip ? 1 : 0, bad_stop ? 1 : 0, tag);
  endtask

  initial begin
    int  data;
    bit  flip, bad;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) rx[k] = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset d_out[%0d]", k), 32'(dout[k]), 32'd0);
      check($sformatf("reset fifo_we[%0d]", k), 32'(we[k]), 32'd0);
      check($sformatf("reset parity_err[%0d]", k), 32'(pe[k]), 32'd0);
      check($sformatf("reset frame_err[%0d]", k), 32'(fe[k]), 32'd0);
      check($sformatf("reset busy[%0d]", k), 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;
    wait_ticks(8);

    frame(0, 'hA5, 1'b0, 1'b0, "even A5");

    frame(1, 'h5A, 1'b0, 1'b0, "odd 5A");
    frame(1, 'h3C, 1'b1, 1'b0, "odd 3C bad parity");

    // Short low glitch: start is seen, then rejected at the mid-bit sample.
    mark(0);
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 24);
    check("glitch busy rise", 32'(n_rise[0] - b_rise[0]), 32'd1);
    check_frame(0, 0, 0, 0, "glitch");

    // Bad stop bit followed by a held-low break, then a clean frame.
    mark(0);
    send(0, 'h96, 1'b0, 1'b1);
    drive(0, 1'b0, 3 * 16);
    check("break busy held", 32'(busy[0]), 32'd1);
    check("break frame_err count", 32'(n_fe[0] - b_fe[0]), 32'd1);
    check("break parity_err count", 32'(n_pe[0] - b_pe[0]), 32'd0);
    check("break fifo_we count", 32'(n_we[0] - b_we[0]), 32'd0);
    check("break result ticks", 32'(lat[0]), 32'(exp_lat(0)));
    drive(0, 1'b1, 8);
    check("break released busy", 32'(busy[0]), 32'd0);
    check("break d_out kept", 32'(dout[0]), 32'(exp_word[0]));
    frame(0, 'h55, 1'b0, 1'b0, "after break 55");

    // Back-to-back frames, no idle gap.
    mark(2);
    send(2, 'h00, 1'b0, 1'b0);
    send(2, 'hFF, 1'b0, 1'b0);
    drive(2, 1'b1, 32);
    exp_word[2] = 'hFF;
    check_frame(2, 2, 0, 0, "b2b");
    check("b2b first word", 32'(prev_word[2]), 32'h00);

    // Reset in the middle of the data field.
    mark(0);
    rx[0] = 1'b0;
    wait_ticks(8 + 16 * 2 + 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst d_out", 32'(dout[0]), 32'd0);
    check("midrst fifo_we", 32'(we[0]), 32'd0);
    check("midrst parity_err", 32'(pe[0]), 32'd0);
    check("midrst frame_err", 32'(fe[0]), 32'd0);
    check("midrst busy", 32'(busy[0]), 32'd0);
    for (int k = 0; k < 4; k++) exp_word[k] = 0;
    rx[0] = 1'b1;
    wait_ticks(4);
    rst = 1'b0;
    wait_ticks(32);
    check("midrst no strobe", 32'(n_we[0] - b_we[0] + n_pe[0] - b_pe[0] + n_fe[0] - b_fe[0]), 32'd0);
    frame(0, 'h81, 1'b0, 1'b0, "after reset 81");

    frame(3, 'h15, 1'b0, 1'b0, "w5 os8 15");

    // Randomised frames with occasional parity / stop corruption.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 5; n++) begin
        data = int'($urandom_range(0, (1 << cfg_w[k]) - 1));
        flip = (cfg_p[k] != 0) && ($urandom_range(0, 3) == 0);
        bad  = ($urandom_range(0, 4) == 0);
        frame(k, data, flip, bad, $sformatf("rand[%0d.%0d] %0h p%0d s%0d", k, n, data, flip, bad));
      end
    end

    for (int k = 0; k < 4; k++)
      check($sformatf("pulse width[%0d]", k), 32'(n_wide[k]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
